// File: rtl/hex_fetch_if.sv
// Bus bundle for the hex fetch stage: branch redirect, instruction memory
// port and the instruction hand-off towards execute.
interface hex_fetch_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
);
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_opc;
  logic [DATA_WIDTH-1:0] out_oreg;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [ADDR_WIDTH-1:0] out_next_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_rvalid, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_opc, out_oreg, out_pc, out_next_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_rvalid, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_opc, out_oreg, out_pc, out_next_pc
  );
endinterface

// File: rtl/hex_fetch.sv
// Instruction fetch for the hex processor: fetches 32-bit words, walks their
// bytes, folds PFIX/NFIX prefixes into oreg and issues complete instructions.
module hex_fetch #(
  parameter int                    ADDR_WIDTH = 18,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic        clk,
  input  logic        rst,
  hex_fetch_if.master bus
);
  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] ISSUE  = 2'd2;
  localparam logic [3:0] PFIX   = 4'hD;
  localparam logic [3:0] NFIX   = 4'hE;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_oreg;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_drop;
  logic                  r_mem_req;
  logic                  r_out_valid;
  logic [3:0]            r_out_opc;
  logic [DATA_WIDTH-1:0] r_out_oreg;
  logic [ADDR_WIDTH-1:0] r_out_pc;
  logic [ADDR_WIDTH-1:0] r_out_next_pc;

  logic [1:0]            w_state_next;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [DATA_WIDTH-1:0] w_oreg_next;
  logic                  w_drop_next;
  logic                  w_word_load;
  logic                  w_load_out;
  logic                  w_clear_out;
  logic [7:0]            w_byte;
  logic [3:0]            w_opc;
  logic [DATA_WIDTH-1:0] w_opr_ext;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [1:0]            w_step_state;
  logic                  w_accept;

  // Little-endian: the low two pc bits select the byte within the held word.
  assign w_byte       = r_word[{r_pc[1:0], 3'b000} +: 8];
  assign w_opc        = w_byte[7:4];
  assign w_opr_ext    = {{(DATA_WIDTH-4){1'b0}}, w_byte[3:0]};
  assign w_pc_inc     = r_pc + ADDR_WIDTH'(1);
  assign w_step_state = (w_pc_inc[1:0] == 2'b00) ? FETCH : DECODE;
  assign w_accept     = bus.mem_rvalid && r_mem_req;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_oreg_next  = r_oreg;
    w_drop_next  = r_drop;
    w_word_load  = 1'b0;
    w_load_out   = 1'b0;
    w_clear_out  = 1'b0;
    if (bus.redirect_valid) begin
      w_state_next = FETCH;
      w_pc_next    = bus.redirect_pc;
      w_oreg_next  = '0;
      w_clear_out  = 1'b1;
      // A request still in flight must have its response swallowed.
      w_drop_next  = (r_state == FETCH) && r_mem_req && !bus.mem_rvalid;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_accept) begin
            if (r_drop) begin
              w_drop_next = 1'b0;
            end else begin
              w_word_load  = 1'b1;
              w_state_next = DECODE;
            end
          end
        end
        DECODE: begin
          if (w_opc == PFIX) begin
            w_oreg_next  = (r_oreg | w_opr_ext) << 4;
            w_pc_next    = w_pc_inc;
            w_state_next = w_step_state;
          end else if (w_opc == NFIX) begin
            w_oreg_next  = {{(DATA_WIDTH-8){1'b1}}, w_byte[3:0], 4'b0000};
            w_pc_next    = w_pc_inc;
            w_state_next = w_step_state;
          end else begin
            w_load_out   = 1'b1;
            w_state_next = ISSUE;
          end
        end
        ISSUE: begin
          if (bus.out_ready) begin
            w_oreg_next  = '0;
            w_pc_next    = w_pc_inc;
            w_clear_out  = 1'b1;
            w_state_next = w_step_state;
          end
        end
        default: w_state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_oreg        <= '0;
      r_word        <= '0;
      r_drop        <= 1'b0;
      r_mem_req     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_opc     <= '0;
      r_out_oreg    <= '0;
      r_out_pc      <= '0;
      r_out_next_pc <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_oreg    <= w_oreg_next;
      r_drop    <= w_drop_next;
      r_mem_req <= (w_state_next == FETCH);
      if (w_word_load) begin
        r_word <= bus.mem_rdata;
      end
      if (w_load_out) begin
        r_out_valid   <= 1'b1;
        r_out_opc     <= w_opc;
        r_out_oreg    <= r_oreg | w_opr_ext;
        r_out_pc      <= r_pc;
        r_out_next_pc <= w_pc_inc;
      end else if (w_clear_out) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = {r_pc[ADDR_WIDTH-1:2], 2'b00};
  assign bus.out_valid   = r_out_valid;
  assign bus.out_opc     = r_out_opc;
  assign bus.out_oreg    = r_out_oreg;
  assign bus.out_pc      = r_out_pc;
  assign bus.out_next_pc = r_out_next_pc;
endmodule

// File: tb/tb_hex_fetch.sv
// Directed bench for hex_fetch: a variable-latency memory model, a handshake
// monitor and hand-computed expected instruction streams.
module tb_hex_fetch;
  localparam int AW = 18;
  localparam int DW = 32;

  typedef struct packed {
    logic [3:0]    opc;
    logic [DW-1:0] oreg;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
  } out_t;

  localparam logic [71:0] EXP_A [5] = '{
    {4'h3, 32'h0000_0000, 18'h0, 18'h1},
    {4'h9, 32'h0000_012F, 18'h3, 18'h4},
    {4'h3, 32'hFFFF_FF5A, 18'h5, 18'h6},
    {4'h0, 32'h0000_0000, 18'h6, 18'h7},
    {4'h4, 32'h0000_0071, 18'h8, 18'h9}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  hex_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(18'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  out_t          outq[$];
  logic [AW-1:0] reqlog[$];
  logic [DW-1:0] mem [int];
  int            n_tests  = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            lat      = 1;
  int            first_rv = -1;
  int            cnt      = 0;
  bit            busy     = 1'b0;
  logic [AW-1:0] cap_addr = '0;

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : '0;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: one outstanding request, rvalid 'lat' cycles after capture.
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        busy           = 1'b0;
        bus.mem_rvalid = 1'b0;
      end else begin
        if (bus.mem_rvalid) begin
          bus.mem_rvalid = 1'b0;
          busy           = 1'b0;
        end else if (busy) begin
          cnt--;
          if (cnt == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rd(cap_addr);
            if (first_rv < 0) first_rv = cyc;
          end
        end
        if (!busy && !bus.mem_rvalid && bus.mem_req) begin
          busy     = 1'b1;
          cnt      = lat;
          cap_addr = bus.mem_addr;
          reqlog.push_back(bus.mem_addr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      outq.push_back(out_t'({bus.out_opc, bus.out_oreg, bus.out_pc, bus.out_next_pc}));
      $display("[TB] issue opc=%0h oreg=%08h pc=%05h next_pc=%05h",
               bus.out_opc, bus.out_oreg, bus.out_pc, bus.out_next_pc);
    end
  end

  task automatic wait_outs(input int n, input string tag);
    int i = 0;
    while (outq.size() < n && i < 400) begin
      @(posedge clk);
      #2;
      i++;
    end
    check_val(tag, 64'(outq.size()), 64'(n));
  endtask

  task automatic wait_valid(input string tag);
    int i = 0;
    while (!bus.out_valid && i < 100) begin
      @(posedge clk);
      #2;
      i++;
    end
    check_val(tag, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic do_redirect(input logic [AW-1:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(posedge clk);
    #2;
    bus.redirect_valid = 1'b0;
    outq.delete();
  endtask

  initial begin
    logic [71:0] e;
    int          idx;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    mem[32'h0]     = 32'h9FD2_D130;
    mem[32'h4]     = 32'hD700_3AE5;
    mem[32'h8]     = 32'h0000_0041;
    mem[32'h100]   = 32'h5527_0000;
    mem[32'h3FFFC] = 32'h5000_0000;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_mem_req",   64'(bus.mem_req),   64'd0);
    check_val("rst_out_oreg",  64'(bus.out_oreg),  64'd0);
    check_val("rst_out_pc",    64'(bus.out_pc),    64'd0);
    check_val("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check_val("first_req",  64'(bus.mem_req),  64'd1);
    check_val("first_addr", 64'(bus.mem_addr), 64'd0);

    // Prefix folding across bytes and words, plus rvalid -> out_valid latency
    wait_valid("a_first_valid");
    check_val("a_latency", 64'(cyc - first_rv), 64'd2);
    wait_outs(5, "a_count");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = EXP_A[i];
      check_val($sformatf("a%0d_opc", i),  64'(outq[i].opc),  64'(e[71:68]));
      check_val($sformatf("a%0d_oreg", i), 64'(outq[i].oreg), 64'(e[67:36]));
      check_val($sformatf("a%0d_pc", i),   64'(outq[i].pc),   64'(e[35:18]));
      check_val($sformatf("a%0d_npc", i),  64'(outq[i].npc),  64'(e[17:0]));
    end

    // Back-pressure: outputs hold, then exactly one instruction is consumed
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      check_val($sformatf("stall%0d_valid", i), 64'(bus.out_valid),   64'd1);
      check_val($sformatf("stall%0d_pc", i),    64'(bus.out_pc),      64'h9);
      check_val($sformatf("stall%0d_npc", i),   64'(bus.out_next_pc), 64'hA);
      check_val($sformatf("stall%0d_opc", i),   64'(bus.out_opc),     64'h0);
    end
    check_val("stall_count", 64'(outq.size()), 64'd5);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b0;
    check_val("one_count", 64'(outq.size()), 64'd6);
    check_val("one_pc", 64'(outq[5].pc), 64'h9);
    check_val("one_valid_drop", 64'(bus.out_valid), 64'd0);
    wait_valid("one_next_valid");
    check_val("one_next_pc", 64'(bus.out_pc), 64'hA);

    // Redirect while a slow fetch of 0x000 is outstanding
    bus.out_ready = 1'b1;
    lat = 3;
    reqlog.delete();
    do_redirect(18'h0);
    check_val("r_outstanding", 64'(busy), 64'd1);
    do_redirect(18'h102);
    wait_outs(1, "r_count");
    check_val("r_pc",   64'(outq[0].pc),   64'h102);
    check_val("r_npc",  64'(outq[0].npc),  64'h103);
    check_val("r_opc",  64'(outq[0].opc),  64'h2);
    check_val("r_oreg", 64'(outq[0].oreg), 64'h7);
    check_val("r_req0", 64'(reqlog[0]),    64'h0);
    check_val("r_req1", 64'(reqlog[1]),    64'h100);

    // PC wrap at the top of the address space
    lat = 1;
    reqlog.delete();
    do_redirect(18'h3FFFF);
    wait_outs(2, "w_count");
    bus.out_ready = 1'b0;
    check_val("w_pc",   64'(outq[0].pc),   64'h3FFFF);
    check_val("w_npc",  64'(outq[0].npc),  64'h0);
    check_val("w_opc",  64'(outq[0].opc),  64'h5);
    check_val("w2_pc",  64'(outq[1].pc),   64'h0);
    check_val("w2_opc", 64'(outq[1].opc),  64'h3);
    idx = -1;
    foreach (reqlog[k]) if (idx < 0 && reqlog[k] == 18'h3FFFC) idx = k;
    check_val("w_req_found", 64'(idx >= 0), 64'd1);
    if (idx >= 0) check_val("w_req_next", 64'(reqlog[idx+1]), 64'h0);

    // Asynchronous reset while an instruction waits in ISSUE
    wait_valid("x_valid");
    reqlog.delete();
    #1;
    rst = 1'b1;
    #1;
    check_val("x_valid_drop", 64'(bus.out_valid), 64'd0);
    check_val("x_req_drop",   64'(bus.mem_req),   64'd0);
    check_val("x_pc_zero",    64'(bus.out_pc),    64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2;
    check_val("x_req",      64'(bus.mem_req),   64'd1);
    check_val("x_addr",     64'(bus.mem_addr),  64'h0);
    check_val("x_log_size", 64'(reqlog.size()), 64'd1);
    check_val("x_log_addr", 64'(reqlog[0]),     64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hex_fetch.md
Name: hex_fetch

Overview:
- Instruction fetch and prefix-folding stage for the hex processor; sits between instruction memory and the execute stage.
- Fetches 32-bit words and splits each into four 8-bit instructions: opcode in bits [7:4], operand in bits [3:0].
- Absorbs PFIX/NFIX prefixes internally; delivers each non-prefix instruction to execute with its fully assembled 32-bit operand and PC values.
- Branch redirects from execute flush the stage.

Parameters:
- ADDR_WIDTH, 18, byte address width.
- DATA_WIDTH, 32, memory word and operand width.
- RESET_PC, 0, byte address of the first fetch after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new byte PC; any alignment allowed
- mem_req  out  1  fetch request, held until mem_rvalid
- mem_addr  out  ADDR_WIDTH  word-aligned fetch address, bits [1:0] always 0
- mem_rvalid  in  1  read data valid; variable latency of 1 or more cycles
- mem_rdata  in  DATA_WIDTH  read word
- out_valid  out  1  instruction available
- out_ready  in  1  execute accepts the instruction
- out_opc  out  4  opcode; never PFIX (13) or NFIX (14)
- out_oreg  out  DATA_WIDTH  assembled operand (oreg | opr)
- out_pc  out  ADDR_WIDTH  byte address of the instruction
- out_next_pc  out  ADDR_WIDTH  out_pc+1, mod 2^ADDR_WIDTH

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, oreg 0, buffer empty, state FETCH, pc = RESET_PC.
  - First cycle after release: mem_req=1, mem_addr={pc[17:2],2'b00}.
- Byte order is little-endian: byte i of a word is bits [8i+7:8i].
- State FETCH:
  - mem_req held high with a stable address until mem_rvalid.
  - On mem_rvalid: register the word, set the byte index to pc[1:0], go to DECODE.
  - Only one request is outstanding at any time.
- State DECODE: one byte examined per cycle.
  - PFIX: oreg <= (oreg | opr) << 4.
  - NFIX: oreg <= 32'hFFFFFF00 | (opr << 4).
  - For either prefix: pc++; no output produced.
  - Any other opcode, including undefined 15: load the output registers (out_oreg = oreg | zero-extended opr), set out_valid=1, go to ISSUE.
- State ISSUE:
  - Outputs are held stable while out_valid && !out_ready.
  - On handshake: oreg <= 0, pc++, out_valid <= 0.
- Byte stepping: after pc++, if the new byte index wraps to 0 go to FETCH, else go to DECODE.
- Latency: mem_rvalid in cycle N with a non-prefix byte gives out_valid in cycle N+2 (N+1 register word, N+2 output). Each prefix byte adds one cycle.
- PC arithmetic is mod 2^ADDR_WIDTH: 0x3FFFF+1 = 0x00000; the fetch after 0x3FFFC is 0x00000.
- Prefix chains may cross word boundaries; oreg is preserved across the fetch.
- Redirect, any state:
  - Next cycle: pc=redirect_pc, oreg=0, out_valid=0, buffer dropped, state FETCH.
  - If a request is outstanding, mem_req stays high. The pending response is discarded via a drop flag, then a new request is issued at the redirect address. No stale byte may reach the output.
  - Redirect coincident with mem_rvalid: that data is discarded.
  - Redirect coincident with an out handshake: the handshake counts; the redirect wins for the next instruction.
- An unaligned redirect_pc fetches the aligned word and starts at byte redirect_pc[1:0].

Test Plan:
- Word 0 = 0x9FD2D130 -> outputs:
  - opc 3, oreg 0, pc 0;
  - then opc 9, oreg 0x12F, pc 3, next_pc 4;
  - no output for the D1/D2 prefix bytes.
- Bytes E5, 3A -> opc 3, oreg 0xFFFFFF5A.
- PFIX 0xD7 at byte 3, 0x2 opr byte 0x41 in next word -> opc 4, oreg 0x71, pc = next word base.
- out_ready held low 5 cycles -> all outputs constant; exactly one instruction consumed when ready rises.
- Redirect to 0x102 while a fetch of 0x000 is outstanding, memory latency 3:
  - first response is discarded;
  - next mem_addr is 0x100;
  - first output has pc 0x102.
- pc 0x3FFFF with a non-prefix byte -> out_next_pc 0; next mem_addr 0x00000.
- Reset asserted during ISSUE -> out_valid and mem_req drop immediately (asynchronously); after release the first request is to RESET_PC.
